rr_arbiter8: RTL
================

// Module: rr_arbiter8
// PURPOSE
//  Round-robin arbiter sharing one resource among 8 requesters.
//  - Arbitrates req[7:0] and returns a registered grant as a 3-bit index plus its one-hot form.
//  - The one-hot form is the 3-to-8 decode of the index.
//  - A per-grant hold timer forces release from requesters that hog the resource.
//  - Sits between requesting engines and any resource selected by a 3-bit select/one-hot enable.
// PARAMETERS
//  MAX_HOLD  16  max cycles a grant may be held; 0 = unlimited (timer disabled)
//  CNT_W     5   hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  req        in   8  request per requester; level, held until served
//  gnt_valid  out  1  a grant is active
//  gnt_idx    out  3  index of granted requester; 0 when gnt_valid=0
//  gnt        out  8  one-hot decode of gnt_idx gated by gnt_valid; 8'h00 when idle
//  timeout    out  1  one-cycle pulse on the cycle after a forced release
// BEHAVIOUR
//  Reset (async assert, sync deassert by the clk domain):
//  - gnt_valid=0, gnt_idx=0, gnt=0, timeout=0.
//  - ptr=0, hold_cnt=0, lockout=8'h00, state=IDLE.
//  FSM states: IDLE, GRANT. All outputs are registered.
//  IDLE:
//  - eligible = req & ~lockout.
//  - If eligible != 0, the winner is the first set bit at or after ptr, searching upward with wrap 7->0.
//  - Next edge: gnt_idx=winner, gnt_valid=1, hold_cnt=0, state goes to GRANT.
//  - Latency from req high (idle arbiter) to gnt high: 1 clock.
//  GRANT, each edge:
//  - If req[gnt_idx]=0: normal release. Next edge gnt_valid=0, gnt=0, gnt_idx=0, ptr=gnt_idx+1 (mod 8), state goes to IDLE.
//  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: forced release. Same updates as a normal release, plus timeout=1 for one cycle and lockout[gnt_idx]=1.
//  - Else: hold_cnt increments; the grant is unchanged.
//  Turnaround: at least one idle cycle (gnt=0) between consecutive grants.
//  - Guarantees resource select is never switched while enabled.
//  Lockout:
//  - lockout[i] clears on any edge where req[i]=0.
//  - A timed-out requester must drop req for one or more cycles before it is eligible again.
//  Fairness: after serving i, every other eligible requester is served before i again.
//  Simultaneous req drop and timer expiry: treat as a normal release; no timeout, no lockout.
//  New requests arriving during GRANT do not preempt; they are considered in the next IDLE cycle.
//  All eligible requests masked by lockout: stay IDLE with outputs at 0.
//  Reset asserted mid-grant: all outputs drop to reset values immediately (async), with no timeout pulse. Arbitration restarts from ptr=0.
//  Invariants:
//  - gnt has at most one bit set.
//  - gnt==0 iff gnt_valid==0.
//  - Whenever gnt_valid=1, gnt==(8'b1<<gnt_idx).
// TESTING
//  T1 Reset:
//  - rst_n=0 mid-grant, with req=8'hFF.
//  - Outputs are 0 without waiting for a clk edge.
//  - After release, the first grant goes to idx 0.
//  T2 Rotation:
//  - req=8'hFF, each requester drops req 3 cycles after its grant.
//  - Grant order 0,1,...,7,0; gnt=01,02,...,80; exactly 1 idle cycle between grants.
//  T3 Wrap/skip:
//  - ptr=6 (after serving 5), req=8'b0000_0101.
//  - Grant idx 0 (gnt=8'h01), then idx 2.
//  T4 Timeout (MAX_HOLD=16):
//  - req[3] held high.
//  - Grant drops after 16 cycles; timeout pulses 1 cycle.
//  - idx 3 is not regranted while req[3] stays high.
//  - After req[3] is low for 1 cycle and then high again, idx 3 is granted again.
//  T5 Race:
//  - req[4] drops on exactly the cycle hold_cnt==MAX_HOLD-1.
//  - Normal release; timeout stays 0; lockout[4] stays 0.
//  T6 Random:
//  - 10k cycles of random req with random holds, MAX_HOLD=0 and MAX_HOLD=4.
//  - Check onehot0(gnt), gnt==decode(gnt_idx) while valid, and the fairness bound.
//  - Fairness bound: no eligible requester waits more than 7 grants.

Source files
------------

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Brief    : Round-robin arbiter for 8 requesters with a registered index and
//            one-hot grant. A per-grant hold timer forces release and locks out
//            a requester until it drops its request.
// Revision : 1.0
// ============================================================================
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout
);

  localparam logic [0:0]       c_IDLE      = 1'b0;
  localparam logic [0:0]       c_GRANT     = 1'b1;
  localparam bit               c_TIMER_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(c_TIMER_EN ? MAX_HOLD - 1 : 0);

  logic [0:0]       r_state,    w_state_nxt;
  logic [2:0]       r_ptr,      w_ptr_nxt;
  logic [2:0]       r_idx,      w_idx_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [7:0]       r_lockout,  w_lockout_nxt;
  logic             r_timeout,  w_timeout_nxt;
  logic [7:0]       r_gnt,      w_gnt_nxt;

  logic [7:0]       w_eligible;
  logic             w_found;
  logic [2:0]       w_winner;
  logic [2:0]       w_cand;
  logic             w_release;
  logic             w_forced;

  assign w_eligible = req & ~r_lockout;

  // First eligible requester at or after the pointer, wrapping 7 -> 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_cand   = r_ptr;
    for (int k = 0; k < 8; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_found && w_eligible[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // State register together with the registered datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_ptr      <= 3'd0;
      r_idx      <= 3'd0;
      r_hold_cnt <= '0;
      r_lockout  <= 8'h00;
      r_timeout  <= 1'b0;
      r_gnt      <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_idx      <= w_idx_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_lockout  <= w_lockout_nxt;
      r_timeout  <= w_timeout_nxt;
      r_gnt      <= w_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_idx_nxt      = r_idx;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;
    w_lockout_nxt  = r_lockout & req;
    w_release      = 1'b0;
    w_forced       = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_found) begin
          w_state_nxt    = c_GRANT;
          w_idx_nxt      = w_winner;
          w_hold_cnt_nxt = '0;
        end
      end
      c_GRANT: begin
        // A dropped request wins over a simultaneous timer expiry.
        if (!req[r_idx]) begin
          w_release = 1'b1;
        end else if (c_TIMER_EN && (r_hold_cnt == c_HOLD_LAST)) begin
          w_release = 1'b1;
          w_forced  = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
        if (w_release) begin
          w_state_nxt = c_IDLE;
          w_idx_nxt   = 3'd0;
          w_ptr_nxt   = r_idx + 3'd1;
        end
        if (w_forced) begin
          w_timeout_nxt          = 1'b1;
          w_lockout_nxt[r_idx]   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
    w_gnt_nxt = (w_state_nxt == c_GRANT) ? (8'd1 << w_idx_nxt) : 8'h00;
  end

  always_comb begin
    gnt_valid = (r_state == c_GRANT);
    gnt_idx   = r_idx;
    gnt       = r_gnt;
    timeout   = r_timeout;
  end

endmodule
`default_nettype wire
